// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial unsigned subtractor, diff = a - b, processed one bit
//            per clock LSB first with a registered borrow. Start/busy/done
//            handshake; results hold until the next operation completes.
// Ports    : clk        - rising-edge clock
//            rst        - synchronous active-high reset
//            start      - operation request (accepted in IDLE or DONE)
//            a, b       - minuend / subtrahend, captured on accepted start
//            busy       - high while bits are being processed
//            done       - one-cycle pulse, diff/borrow_out valid from here
//            diff       - (a - b) mod 2^WIDTH
//            borrow_out - 1 when a < b (unsigned)
//            overflow   - signed overflow flag (SERIAL_SUB_OVERFLOW_EN only)
// Options  : define SERIAL_SUB_OVERFLOW_EN to add the overflow output.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int            C_CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [C_CW-1:0] C_LAST_BIT = C_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [WIDTH-1:0]  r_sa;        // minuend shift register
    logic [WIDTH-1:0]  r_sb;        // subtrahend shift register
    logic [WIDTH-2:0]  r_sr;        // result bits collected so far
    logic              r_br;        // running borrow
    logic [C_CW-1:0]   r_cnt;       // index of the bit processed this cycle

    logic              w_accept;
    logic              w_last;
    logic              w_x;
    logic              w_y;
    logic              w_d;
    logic              w_br_next;
    // New result bit prepended to the collected bits; the upper WIDTH-1 bits
    // are the next shift-register content, the full vector is the final
    // result on the last bit.
    logic [WIDTH-1:0]  w_sr_cat;

`ifdef SERIAL_SUB_OVERFLOW_EN
    // Operand sign bits are shifted out of SA/SB, so keep them separately.
    logic              r_a_msb;
    logic              r_b_msb;
`endif

    // ------------------------------------------------------------------------
    // Bit-slice subtract and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_x       = r_sa[0];
        w_y       = r_sb[0];
        w_d       = w_x ^ w_y ^ r_br;
        w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
        w_sr_cat  = {w_d, r_sr};
        w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_last    = (r_state == S_RUN) && (r_cnt == C_LAST_BIT);
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == C_LAST_BIT) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                // A start here chains straight into the next operation.
                w_state_next = start ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: operand capture, serial shift, result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa       <= '0;
            r_sb       <= '0;
            r_sr       <= '0;
            r_br       <= 1'b0;
            r_cnt      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (w_accept) begin
            r_sa  <= a;
            r_sb  <= b;
            r_sr  <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
            r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
            r_sr  <= w_sr_cat[WIDTH-1:1];
            r_br  <= w_br_next;
            r_cnt <= r_cnt + C_CW'(1);
            // Results are committed on the edge entering DONE so they are
            // already valid in the cycle where done is high.
            if (w_last) begin
                diff       <= w_sr_cat;
                borrow_out <= w_br_next;
            end
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            overflow <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (w_last) begin
            // Signed overflow: operands differ in sign and the result sign
            // disagrees with the minuend.
            overflow <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor (WIDTH=8). A cycle
//            model computes expected handshake and results arithmetically;
//            directed operations add literal expectations.
// Options  : define SERIAL_SUB_OVERFLOW_EN to also check overflow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             overflow;
`endif

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: phase 0 = idle, 1..WIDTH = working, WIDTH+1 = done.
    // Result computed with plain integer arithmetic on the captured operands.
    // ------------------------------------------------------------------------
    int               m_phase = 0;
    bit               m_valid = 1'b0;
    logic [WIDTH-1:0] m_a = '0;
    logic [WIDTH-1:0] m_b = '0;
    logic [WIDTH-1:0] m_diff = '0;
    logic             m_br = 1'b0;
    logic             m_ovf = 1'b0;

    always @(posedge clk) begin
        int sd;
        if (rst) begin
            m_phase = 0;
            m_diff  = '0;
            m_br    = 1'b0;
            m_ovf   = 1'b0;
            m_valid = 1'b1;
        end else if ((m_phase == 0 || m_phase == WIDTH + 1) && start) begin
            m_phase = 1;
            m_a     = a;
            m_b     = b;
        end else if (m_phase >= 1 && m_phase <= WIDTH) begin
            m_phase++;
            if (m_phase == WIDTH + 1) begin
                m_diff = WIDTH'(int'(m_a) - int'(m_b));
                m_br   = (m_a < m_b);
                sd     = int'($signed(m_a)) - int'($signed(m_b));
                m_ovf  = (sd > 127) || (sd < -128);
            end
        end else begin
            m_phase = 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= WIDTH));
            chk("done", 32'(done), 32'(m_phase == WIDTH + 1));
            chk("diff", 32'(diff), 32'(m_diff));
            chk("borrow_out", 32'(borrow_out), 32'(m_br));
`ifdef SERIAL_SUB_OVERFLOW_EN
            chk("overflow", 32'(overflow), 32'(m_ovf));
`endif
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for done; n = negedges seen including the done one,
    // nb = negedges with busy high before done. n = -1 if it never came.
    task automatic wait_done(output int n, output int nb);
        n  = -1;
        nb = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n = i;
                break;
            end
            if (busy === 1'b1) nb++;
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] ed,
                                input logic eb, input logic eo);
        chk({tag, " diff"}, 32'(diff), 32'(ed));
        chk({tag, " borrow"}, 32'(borrow_out), 32'(eb));
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk({tag, " ovf"}, 32'(overflow), 32'(eo));
`else
        if (eo === 1'bx) $display("note: unexpected X flag in %s", tag);
`endif
    endtask

    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [7:0] ed, input logic eb, input logic eo);
        int n, nb;
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        tick;
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        wait_done(n, nb);
        chk({tag, " latency"}, 32'(n), 32'd9);
        chk({tag, " busy cycles"}, 32'(nb), 32'd8);
        check_result(tag, ed, eb, eo);
        tick;
    endtask

    initial begin
        int n, nb, d0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick;
        tick;
        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        check_result("reset", 8'h00, 1'b0, 1'b0);
        tick;
        rst = 1'b0;
        tick;

        // Basic and boundary operations
        run_op("t1", 8'h3C, 8'h15, 8'h27, 1'b0, 1'b0);
        run_op("t2a", 8'h05, 8'h09, 8'hFC, 1'b1, 1'b0);
        run_op("t2b", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
        run_op("t2c", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);

        // Start while busy is ignored
        d0    = done_cnt;
        start = 1'b1;
        a     = 8'h80;
        b     = 8'h10;
        tick;
        start = 1'b0;
        tick;
        tick;
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h02;
        tick;
        start = 1'b0;
        wait_done(n, nb);
        chk("t3 latency", 32'(n), 32'd6);
        check_result("t3", 8'h70, 1'b0, 1'b1);
        repeat (12) @(negedge clk);
        chk("t3 done count", 32'(done_cnt - d0), 32'd1);

        // Back-to-back: start held through DONE
        tick;
        start = 1'b1;
        a     = 8'h20;
        b     = 8'h08;
        tick;
        a     = 8'h10;
        b     = 8'h20;
        wait_done(n, nb);
        chk("t4a latency", 32'(n), 32'd9);
        check_result("t4a", 8'h18, 1'b0, 1'b0);
        tick;
        start = 1'b0;
        wait_done(n, nb);
        chk("t4b spacing", 32'(n), 32'd9);
        chk("t4b busy cycles", 32'(nb), 32'd8);
        check_result("t4b", 8'hF0, 1'b1, 1'b0);
        tick;

        // Reset mid-operation
        start = 1'b1;
        a     = 8'h3C;
        b     = 8'h15;
        tick;
        start = 1'b0;
        tick;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("t5 busy", 32'(busy), 32'd0);
        chk("t5 done", 32'(done), 32'd0);
        check_result("t5 rst", 8'h00, 1'b0, 1'b0);
        d0 = done_cnt;
        repeat (12) @(negedge clk);
        chk("t5 no done", 32'(done_cnt - d0), 32'd0);
        run_op("t5b", 8'h0A, 8'h03, 8'h07, 1'b0, 1'b0);

        // Signed-overflow corner operands
        run_op("t6a", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op("t6b", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        run_op("t6c", 8'h10, 8'h05, 8'h0B, 1'b0, 1'b0);

        repeat (3) tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
